// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer_if
//  Description : Fetch-side and decode-side signals of the instruction fetch
//                buffer, with modports for the buffer and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if #(
   parameter int XLEN = 32
);
   logic            fetch_valid;
   logic [XLEN-1:0] pc_in;
   logic [XLEN-1:0] imem_rdata;
   logic            flush;
   logic            id_ready;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_instr;
   logic            stall;

   // The buffer itself
   modport slave (
      input  fetch_valid, pc_in, imem_rdata, flush, id_ready,
      output id_valid, id_pc, id_instr, stall
   );

   // PC stage, instruction memory and decode
   modport master (
      output fetch_valid, pc_in, imem_rdata, flush, id_ready,
      input  id_valid, id_pc, id_instr, stall
   );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Captures issued fetch PCs and the 1-cycle-late imem data,
//                queues {pc, instr} pairs for decode; stalls and flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input wire            clk,
   input wire            reset,
   fetch_buffer_if.slave bus
);
   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);

   logic            r_if_v;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_mem_pc    [DEPTH];
   logic [XLEN-1:0] r_mem_instr [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;

   logic            w_acc;
   logic            w_push;
   logic            w_pop;
   logic            w_stall;
   logic            w_id_valid;
   logic [AW+1:0]   w_occupancy;

   // Occupancy counts the in-flight fetch so a push can never meet a full FIFO
   assign w_occupancy = {1'b0, r_count} + (AW+2)'(r_if_v);
   assign w_stall     = (w_occupancy >= C_DEPTH);

   assign w_id_valid  = (r_count != '0) & ~bus.flush;
   assign w_acc       = bus.fetch_valid & ~w_stall & ~bus.flush;
   assign w_push      = r_if_v & ~bus.flush;
   assign w_pop       = w_id_valid & bus.id_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_if_v  <= 1'b0;
         r_if_pc <= '0;
      end else begin
         r_if_v <= w_acc;
         if (w_acc) begin
            r_if_pc <= bus.pc_in;
         end
      end
   end

   // Storage is deliberately not reset; count/pointers define what is live
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= r_if_pc;
         r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.id_valid = w_id_valid;
   assign bus.id_pc    = w_id_valid ? r_mem_pc[r_rd_ptr]    : '0;
   assign bus.id_instr = w_id_valid ? r_mem_instr[r_rd_ptr] : '0;
   assign bus.stall    = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Randomised scoreboard bench for fetch_buffer against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic clk;
   logic reset;

   fetch_buffer_if #(.XLEN(XLEN)) bus ();

   fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Every accepted fetch not yet popped or flushed, oldest first; the newest
   // is still in flight when m_ifv is set.
   entry_t      exp_q[$];
   bit          m_ifv      = 1'b0;
   bit          prev_acc   = 1'b0;
   bit          prev_fl    = 1'b0;
   logic [31:0] prev_pc    = '0;
   logic [31:0] last_pc_in = '0;
   logic [31:0] next_pc    = '0;
   bit          mon_en     = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Apply the effect of the edge that just happened to the model
   function automatic void finalize();
      entry_t e;
      if (prev_fl) begin
         exp_q.delete();
         m_ifv = 1'b0;
      end else begin
         m_ifv = prev_acc;
         if (prev_acc) begin
            e.pc    = prev_pc;
            e.instr = prev_pc ^ 32'h13;
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic void apply(input bit fv, input bit rdy, input bit fl);
      bit stall_m;
      bus.fetch_valid = fv;
      bus.id_ready    = rdy;
      bus.flush       = fl;
      bus.imem_rdata  = last_pc_in ^ 32'h13;
      bus.pc_in       = fl ? 32'h40 : next_pc;
      last_pc_in      = bus.pc_in;
      stall_m         = (exp_q.size() >= DEPTH);
      prev_acc        = fv && !stall_m && !fl;
      prev_pc         = bus.pc_in;
      prev_fl         = fl;
      if (prev_acc) next_pc = next_pc + 32'd4;
      if (fl) next_pc = 32'h100 + ($urandom_range(0, 63) << 4);
   endfunction

   task automatic drive_cycle(input bit fv, input bit rdy, input bit fl);
      @(posedge clk);
      #1;
      finalize();
      apply(fv, rdy, fl);
   endtask

   // Asynchronous reset pulsed between edges, outputs checked before any edge
   task automatic reset_pulse();
      @(posedge clk);
      #1;
      finalize();
      bus.fetch_valid = 1'b0;
      bus.id_ready    = 1'b0;
      bus.flush       = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
      chk("rst_id_pc",    bus.id_pc,    32'd0);
      chk("rst_id_instr", bus.id_instr, 32'd0);
      chk("rst_stall",    {31'd0, bus.stall}, 32'd0);
      reset = 1'b0;
      exp_q.delete();
      m_ifv    = 1'b0;
      prev_acc = 1'b0;
      prev_fl  = 1'b0;
      next_pc  = 32'h200;
   endtask

   // Monitor: compares against the model mid-cycle and pops on handshake
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            int cnt;
            bit ev;
            cnt = exp_q.size() - (m_ifv ? 1 : 0);
            ev  = (cnt > 0) && !bus.flush;
            chk("stall", {31'd0, bus.stall}, {31'd0, exp_q.size() >= DEPTH});
            chk("id_valid", {31'd0, bus.id_valid}, {31'd0, ev});
            if (ev) begin
               chk("id_pc",    bus.id_pc,    exp_q[0].pc);
               chk("id_instr", bus.id_instr, exp_q[0].instr);
               if (bus.id_ready) void'(exp_q.pop_front());
            end else begin
               chk("idle_id_pc",    bus.id_pc,    32'd0);
               chk("idle_id_instr", bus.id_instr, 32'd0);
            end
         end
      end
   end

   initial begin
      reset           = 1'b1;
      bus.fetch_valid = 1'b0;
      bus.id_ready    = 1'b0;
      bus.flush       = 1'b0;
      bus.pc_in       = '0;
      bus.imem_rdata  = '0;
      #3;
      chk("por_id_valid", {31'd0, bus.id_valid}, 32'd0);
      chk("por_id_pc",    bus.id_pc,    32'd0);
      chk("por_stall",    {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      apply(1'b1, 1'b1, 1'b0);

      // Straight-line fetch with decode always ready
      repeat (20) drive_cycle(1'b1, 1'b1, 1'b0);
      // Back-pressure then drain
      repeat (10) drive_cycle(1'b1, 1'b0, 1'b0);
      repeat (10) drive_cycle(1'b1, 1'b1, 1'b0);
      // Flush with a full queue and a valid head offered to decode
      repeat (4)  drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b1);
      repeat (6)  drive_cycle(1'b1, 1'b1, 1'b0);
      // Reset with entries queued
      repeat (4)  drive_cycle(1'b1, 1'b0, 1'b0);
      reset_pulse();
      repeat (8)  drive_cycle(1'b1, 1'b1, 1'b0);
      // Random traffic, wrap-around and occasional redirects
      for (int i = 0; i < 400; i++) begin
         drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 19) == 0);
      end
      // Drain everything still owed to decode
      repeat (12) drive_cycle(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("drained", exp_q.size(), 32'd0);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
